// File: rtl/div_iter_unit_pkg.sv
// Shared definitions for the iterative divider: default widths, FSM state
// encoding and the EX-stage opcodes that select DIV/DIVU.
package div_iter_unit_pkg;

  localparam int unsigned DIV_DATA_W = 32;
  localparam int unsigned DIV_CNT_W  = 6;

  // ALU opcodes decoded upstream into start_i / signed_div_i
  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

endpackage

// File: rtl/div_iter_unit_sign_fix.sv
// div_sign_fix: combinational conditional two's-complement negate.
// Used for absolute values on entry and for the sign fix-up of the result.
//   val_i  operand
//   neg_i  1 = return -val_i, 0 = pass through
//   val_c  result (combinational)
module div_sign_fix
  import div_iter_unit_pkg::*;
#(
  parameter int unsigned W = DIV_DATA_W
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] val_c
);

  always_comb begin
    val_c = neg_i ? W'(~val_i + W'(1)) : val_i;
  end

endmodule

// File: rtl/div_iter_unit.sv
// div_iter_unit: iterative radix-2 restoring divider for DIV/DIVU in EX.
// One quotient bit per cycle; result is {remainder, quotient}.
// Optional feature macro: DIV_EARLY_OUT_EN (when |dividend| < |divisor| the
// result is known at start and the iteration loop is skipped).
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-low reset
//   signed_div_i  1 = DIV (signed), 0 = DIVU
//   opdata1_i     dividend
//   opdata2_i     divisor
//   start_i       request, held until ready_o
//   annul_i       abort of an in-flight division
//   result_o      {remainder, quotient}
//   ready_o       result valid
//   busy_o        division in flight (pipeline stall)
module div_iter_unit
  import div_iter_unit_pkg::*;
#(
  parameter int unsigned DATA_W = DIV_DATA_W,
  parameter int unsigned CNT_W  = DIV_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  busy_o
);

  div_state_e state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rem_q, rem_d;      // partial remainder
  logic [DATA_W-1:0]   dvd_q, dvd_d;      // dividend shifting out / quotient shifting in
  logic [DATA_W-1:0]   dvs_q, dvs_d;      // |divisor|
  logic                neg_quo_q, neg_quo_d;
  logic                neg_rem_q, neg_rem_d;
  logic                fix_q, fix_d;      // 0 only for divide-by-zero (raw result)
  logic [2*DATA_W-1:0] result_q, result_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;

  logic [DATA_W-1:0]   abs_dvd_c, abs_dvs_c;
  logic [DATA_W-1:0]   quo_fix_c, rem_fix_c;
  logic [DATA_W:0]     shift_c;
  logic                ge_c;
  logic [DATA_W-1:0]   rem_next_c;

  // Absolute values of the incoming operands (0x8000_0000 stays 2^31 unsigned)
  div_sign_fix #(.W(DATA_W)) u_abs_dvd (
    .val_i (opdata1_i),
    .neg_i (signed_div_i & opdata1_i[DATA_W-1]),
    .val_c (abs_dvd_c)
  );

  div_sign_fix #(.W(DATA_W)) u_abs_dvs (
    .val_i (opdata2_i),
    .neg_i (signed_div_i & opdata2_i[DATA_W-1]),
    .val_c (abs_dvs_c)
  );

  // Sign fix-up of the finished magnitudes
  div_sign_fix #(.W(DATA_W)) u_fix_quo (
    .val_i (dvd_q),
    .neg_i (fix_q & neg_quo_q),
    .val_c (quo_fix_c)
  );

  div_sign_fix #(.W(DATA_W)) u_fix_rem (
    .val_i (rem_q),
    .neg_i (fix_q & neg_rem_q),
    .val_c (rem_fix_c)
  );

  // One restoring step; compared at DATA_W+1 bits so the shifted-out bit is kept
  always_comb begin
    shift_c    = {rem_q, dvd_q[DATA_W-1]};
    ge_c       = (shift_c >= {1'b0, dvs_q});
    rem_next_c = ge_c ? DATA_W'(shift_c - {1'b0, dvs_q}) : shift_c[DATA_W-1:0];
  end

  // Next-state and datapath control
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    fix_d     = fix_q;
    result_d  = result_q;
    ready_d   = ready_q;

    case (state_q)
      DIV_FREE: begin
        ready_d = 1'b0;
        if (start_i && !annul_i) begin
          dvs_d     = abs_dvs_c;
          neg_quo_d = signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
          neg_rem_d = signed_div_i & opdata1_i[DATA_W-1];
          cnt_d     = '0;
          if (opdata2_i == '0) begin
            // Raw quotient/remainder are preloaded; BYZERO just spends one cycle
            state_d = DIV_BYZERO;
            fix_d   = 1'b0;
            dvd_d   = '1;
            rem_d   = opdata1_i;
`ifdef DIV_EARLY_OUT_EN
          end else if (abs_dvd_c < abs_dvs_c) begin
            // Quotient is 0, remainder is the dividend; reuse the one-cycle path
            state_d = DIV_BYZERO;
            fix_d   = 1'b1;
            dvd_d   = '0;
            rem_d   = abs_dvd_c;
`endif
          end else begin
            state_d = DIV_ON;
            fix_d   = 1'b1;
            dvd_d   = abs_dvd_c;
            rem_d   = '0;
          end
        end
      end

      DIV_BYZERO: begin
        state_d = DIV_END;
      end

      DIV_ON: begin
        rem_d = rem_next_c;
        dvd_d = {dvd_q[DATA_W-2:0], ge_c};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          state_d = DIV_END;
        end
      end

      DIV_END: begin
        if (start_i) begin
          result_d = {rem_fix_c, quo_fix_c};
          ready_d  = 1'b1;
        end else begin
          state_d = DIV_FREE;
          ready_d = 1'b0;
        end
      end

      default: begin
        state_d = DIV_FREE;
      end
    endcase

    // Abort drops back to idle; the last published result is kept
    if (annul_i && (state_q != DIV_FREE)) begin
      state_d = DIV_FREE;
      ready_d = 1'b0;
      cnt_d   = '0;
    end

    // Busy follows the state being entered, so it is registered with it
    busy_d = (state_d != DIV_FREE);
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= DIV_FREE;
      cnt_q     <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      fix_q     <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      fix_q     <= fix_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;
  assign busy_o   = busy_q;

endmodule

// File: doc/div_iter_unit.md
Name: div_iter_unit

Overview:
- Iterative radix-2 restoring divider for the EX stage; executes DIV/DIVU.
- Inputs come from the forwarded ALU operands (SrcAE = dividend, SrcBE = divisor).
- Produces {remainder, quotient} for the HI/LO write path.
- Raises busy_o so the hazard unit stalls F/D/E/M while a division is in flight.

Parameters:
- DATA_W, 32, operand width; quotient and remainder are each DATA_W bits.
- CNT_W, 6, iteration-counter width; must satisfy 2^CNT_W > DATA_W.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  reset: synchronous, active-low; sampled only on the rising edge of clk.
- signed_div_i  in  1  1 = DIV (signed), 0 = DIVU.
- opdata1_i  in  DATA_W  dividend.
- opdata2_i  in  DATA_W  divisor.
- start_i  in  1  request; held high by the EX stage until ready_o is seen.
- annul_i  in  1  abort (flush/exception); highest priority after rst.
- result_o  out  2*DATA_W  {remainder[63:32], quotient[31:0]}.
- ready_o  out  1  result valid.
- busy_o  out  1  division in progress; drives the hazard-unit stall.

Behaviour:
- Reset (rst=0 at a clock edge):
  - state=IDLE, result_o=0, ready_o=0, busy_o=0, counter=0.
  - Applies mid-operation too; the partial result is discarded.
- FSM states: IDLE, BYZERO, ON, END.
- IDLE:
  - Leave IDLE when start_i=1 and annul_i=0.
  - On leaving, latch the operands, sign flags and op type; later changes on the inputs are ignored.
  - divisor==0: go to BYZERO.
  - Otherwise: go to ON with counter=0 and partial remainder=0.
  - If signed, take two's-complement absolute values; 0x80000000 is treated as unsigned 2^31.
- ON (one iteration per cycle):
  - Shift {rem, dvd} left by 1.
  - If rem >= divisor, subtract divisor and set quotient bit 1; else set it 0.
  - Compare at DATA_W+1 bits to avoid overflow.
  - After DATA_W iterations (counter==DATA_W-1) go to END.
- BYZERO: one cycle, then END with quotient=all-ones and remainder=latched dividend (team-defined value; MIPS leaves it UNPREDICTABLE).
- END:
  - Sign fix-up when signed:
    - quotient negated if the operand signs differ;
    - remainder takes the dividend's sign.
  - result_o registered, ready_o=1.
  - Stay in END while start_i=1.
  - start_i=0: go to IDLE, ready_o=0. result_o holds its value until the next start.
- busy_o = 1 in BYZERO and ON, and in END while start_i=1; 0 in IDLE.
- Latency: start sampled at edge T. Normal case: ready_o=1 from T+DATA_W+1 (T+33). Divide-by-zero: ready_o=1 from T+2.
- annul_i=1 in any non-IDLE state: next state IDLE, ready_o=0, result_o unchanged.
- annul_i and start_i both high in IDLE: no start.
- Signed overflow 0x80000000 / -1: quotient 0x80000000, remainder 0; this falls out of the abs/negate path.
- A new start_i while busy is impossible by protocol; if it occurs it is ignored.

Optional Feature:
- Macro DIV_EARLY_OUT_EN.
- Defined: in IDLE, if |dividend| < |divisor| (divisor nonzero), go directly to END next cycle with quotient=0 and remainder=dividend (original sign). ready_o is high at T+1 edge+1, i.e. visible from T+2.
- Undefined: every nonzero-divisor operation takes the full DATA_W iterations.
- Results are identical either way; only latency differs.

Decomposition:
- Shared package/defines header:
  - FSM state encodings DIV_FREE, DIV_BYZERO, DIV_ON, DIV_END (2-bit);
  - DATA_W default;
  - existing EXE_DIV_OP/EXE_DIVU_OP codes.
- One natural sub-module: div_sign_fix, a combinational abs/negate helper used at entry and at END.

Test Plan:
- DIVU 100/7:
  - start_i held high -> ready_o rises exactly 33 cycles after start is sampled;
  - result_o=0x00000002_0000000E;
  - busy_o high throughout.
- DIV -7/2 -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1). DIV 7/-2 -> quotient 0xFFFFFFFD, remainder 0x00000001.
- DIV 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0. DIVU 0xFFFFFFFF/1 -> quotient 0xFFFFFFFF, remainder 0.
- Divide by zero, DIVU 0x1234/0 -> ready_o at T+2, result_o=0x00001234_FFFFFFFF.
- Abort cases:
  - annul_i pulsed at iteration 10 -> IDLE next cycle, ready_o never asserts, result_o keeps the previous value;
  - rst=0 at iteration 20 -> all outputs 0 on the next edge;
  - a fresh DIVU 9/3 then completes with 0x00000000_00000003.
- Hold and release: start_i kept high 5 cycles after ready_o -> ready_o and result_o stable; start_i drops -> ready_o=0 the next cycle and result_o is unchanged. With DIV_EARLY_OUT_EN, DIVU 3/10 -> ready_o at T+2, result 0x00000003_00000000.
